// File: rtl/modexp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation controller.
// Holds the operand width default, the minimum idle gap between reductions,
// the number of mod_go cycles during which mod_done is not trusted, and the
// one-hot state encoding used by modexp_ctrl.
package modexp_ctrl_pkg;

  localparam int unsigned MODEXP_BITS    = 128;
  localparam int unsigned MODEXP_MOD_GAP = 2;
  localparam int unsigned MODEXP_IGNORE  = 2;

  typedef enum logic [9:0] {
    S_IDLE  = 10'b00_0000_0001,
    S_LOAD  = 10'b00_0000_0010,
    S_RED_M = 10'b00_0000_0100,
    S_CHECK = 10'b00_0000_1000,
    S_MUL_R = 10'b00_0001_0000,
    S_RED_R = 10'b00_0010_0000,
    S_MUL_B = 10'b00_0100_0000,
    S_RED_B = 10'b00_1000_0000,
    S_GAP   = 10'b01_0000_0000,
    S_FIN   = 10'b10_0000_0000
  } state_e;

endpackage

// File: rtl/modexp_ctrl_mulreg.sv
// Registered W x W -> 2W multiplier used by modexp_ctrl.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   en_i       : load a_i * b_i into the output register
//   a_i, b_i   : W-bit operands
//   p_o        : registered 2W-bit product, held while en_i is low
module mulreg #(
  parameter int unsigned W = 128
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  logic [2*W-1:0] p_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= '0;
    end else if (en_i) begin
      p_q <= {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/modexp_ctrl.sv
// Controller computing C = M^E mod N by right-to-left square-and-multiply,
// using an external shared reduction unit for every "mod N" step.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start, M, E, N   : one-cycle request with operands sampled on that cycle
//   busy             : operation in progress (ignored starts while high)
//   done, err, C     : one-cycle completion pulse, N==0 flag, held result
//   mod_go           : level request to the reduction unit
//   mod_X, mod_Y     : modulus and dividend presented to the reduction unit
//   mod_R, mod_done  : remainder and completion level from the reduction unit
module modexp_ctrl
  import modexp_ctrl_pkg::*;
#(
  parameter int unsigned BITS    = MODEXP_BITS,
  parameter int unsigned MOD_GAP = MODEXP_MOD_GAP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BITS-1:0]   M,
  input  logic [BITS-1:0]   E,
  input  logic [BITS-1:0]   N,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [BITS-1:0]   C,
  output logic              mod_go,
  output logic [2*BITS:0]   mod_X,
  output logic [2*BITS:0]   mod_Y,
  input  logic [BITS-1:0]   mod_R,
  input  logic              mod_done
);

  localparam int unsigned CW    = $clog2(BITS + 1);
  localparam int unsigned GAP_N = (MOD_GAP == 0) ? 1 : MOD_GAP;
  localparam int unsigned GW    = $clog2(GAP_N + 1);

  state_e          state_q, state_d;
  state_e          after_gap_q, after_gap_d;
  logic [BITS-1:0] m_q, m_d, e_q, e_d, n_q, n_d;
  logic [BITS-1:0] r_q, r_d, b_q, b_d, c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [1:0]      ign_q, ign_d;
  logic            done_q, done_d, err_q, err_d;

  logic              mul_en;
  logic [BITS-1:0]   mul_a, mul_b;
  logic [2*BITS-1:0] prod;
  logic              red, red_ack;

  mulreg #(.W(BITS)) u_mul (
    .clk   (clk),
    .reset (reset),
    .en_i  (mul_en),
    .a_i   (mul_a),
    .b_i   (mul_b),
    .p_o   (prod)
  );

  assign red     = (state_q == S_RED_M) || (state_q == S_RED_R) || (state_q == S_RED_B);
  // mod_done is only trusted once mod_go has been high for MODEXP_IGNORE cycles
  assign red_ack = red && mod_done && (ign_q == 2'(MODEXP_IGNORE));

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign C      = c_q;
  assign mod_go = red;
  assign mod_X  = {{(BITS+1){1'b0}}, n_q};
  assign mod_Y  = {1'b0, prod};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      after_gap_q <= S_IDLE;
      m_q         <= '0;
      e_q         <= '0;
      n_q         <= '0;
      r_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      ign_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      after_gap_q <= after_gap_d;
      m_q         <= m_d;
      e_q         <= e_d;
      n_q         <= n_d;
      r_q         <= r_d;
      b_q         <= b_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      ign_q       <= ign_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    after_gap_d = after_gap_q;
    m_d         = m_q;
    e_d         = e_q;
    n_d         = n_q;
    r_d         = r_q;
    b_d         = b_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    done_d      = 1'b0;
    err_d       = err_q;
    mul_en      = 1'b0;
    mul_a       = '0;
    mul_b       = '0;
    ign_d       = '0;
    if (red) begin
      ign_d = (ign_q == 2'(MODEXP_IGNORE)) ? ign_q : ign_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = M;
          e_d     = E;
          n_d     = N;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        cnt_d = '0;
        // R starts as 1 mod N so E==0 with N==1 still yields 0
        r_d   = (n_q == BITS'(1)) ? '0 : BITS'(1);
        // M*1 puts M on the dividend so RED_M yields B = M mod N
        mul_en = 1'b1;
        mul_a  = m_q;
        mul_b  = BITS'(1);
        if (n_q == '0) begin
          c_d     = '0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_RED_M;
        end
      end

      S_RED_M: begin
        if (red_ack) begin
          b_d         = mod_R;
          gap_d       = GW'(GAP_N);
          after_gap_d = S_CHECK;
          state_d     = S_GAP;
        end
      end

      S_CHECK: begin
        if ((e_q == '0) || (cnt_q == CW'(BITS))) begin
          c_d     = r_q;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else if (e_q[0]) begin
          state_d = S_MUL_R;
        end else begin
          state_d = S_MUL_B;
        end
      end

      S_MUL_R: begin
        mul_en  = 1'b1;
        mul_a   = r_q;
        mul_b   = b_q;
        state_d = S_RED_R;
      end

      S_RED_R: begin
        if (red_ack) begin
          r_d     = mod_R;
          gap_d   = GW'(GAP_N);
          state_d = S_GAP;
          // No exponent bits left: consume this bit here and skip the squaring
          if (((e_q >> 1) == '0) || (cnt_q == CW'(BITS - 1))) begin
            e_d         = e_q >> 1;
            cnt_d       = cnt_q + CW'(1);
            after_gap_d = S_CHECK;
          end else begin
            after_gap_d = S_MUL_B;
          end
        end
      end

      S_MUL_B: begin
        mul_en  = 1'b1;
        mul_a   = b_q;
        mul_b   = b_q;
        state_d = S_RED_B;
      end

      S_RED_B: begin
        if (red_ack) begin
          b_d         = mod_R;
          e_d         = e_q >> 1;
          cnt_d       = cnt_q + CW'(1);
          gap_d       = GW'(GAP_N);
          after_gap_d = S_CHECK;
          state_d     = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_q <= GW'(1)) begin
          state_d = after_gap_q;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl: directed cases plus randomized
// operands against a plain-arithmetic golden modexp, with a behavioural
// reduction unit of random latency that also presents stale mod_done
// pulses inside the window the controller must ignore.
module tb_modexp_ctrl;

  localparam int unsigned BITS    = 128;
  localparam int unsigned MOD_GAP = 2;
  localparam int          TIMEOUT = 20000;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [BITS-1:0]   M, E, N;
  logic              busy, done, err;
  logic [BITS-1:0]   C;
  logic              mod_go;
  logic [2*BITS:0]   mod_X, mod_Y;
  logic [BITS-1:0]   mod_R;
  logic              mod_done;

  always #5 clk = ~clk;

  modexp_ctrl #(.BITS(BITS), .MOD_GAP(MOD_GAP)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .M        (M),
    .E        (E),
    .N        (N),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .C        (C),
    .mod_go   (mod_go),
    .mod_X    (mod_X),
    .mod_Y    (mod_Y),
    .mod_R    (mod_R),
    .mod_done (mod_done)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [2*BITS:0] got, input logic [2*BITS:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BITS-1:0] rand_wide();
    logic [BITS-1:0] v;
    v = '0;
    for (int i = 0; i < int'(BITS / 32); i++) v = {v[BITS-33:0], 32'($urandom)};
    return v;
  endfunction

  function automatic logic [BITS-1:0] golden(input logic [BITS-1:0] m, input logic [BITS-1:0] e,
                                              input logic [BITS-1:0] n);
    logic [2*BITS-1:0] r, b, nn;
    if (n == '0) return '0;
    nn = {{BITS{1'b0}}, n};
    r  = (n == BITS'(1)) ? '0 : (2*BITS)'(1);
    b  = {{BITS{1'b0}}, m} % nn;
    for (int i = 0; i < int'(BITS); i++) begin
      if (e[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[BITS-1:0];
  endfunction

  // Reduction unit model and mod_go monitor
  logic [BITS-1:0] cur_n;
  int   lat_lo = 3, lat_hi = 6, long_pct = 0;
  int   red_k = 0, red_lat = 0;
  logic red_glitch = 1'b0;
  logic prev_go = 1'b0, had_fall = 1'b0, go_seen = 1'b0;
  int   low_cnt = 0;
  int   go_rises = 0;

  always @(negedge clk) begin
    if (!mod_go) begin
      mod_done = 1'b0;
      red_k    = 0;
    end else begin
      red_k++;
      if (red_k == 1) begin
        red_lat    = ($urandom_range(0, 99) < long_pct) ? int'($urandom_range(3, 300))
                                                         : int'($urandom_range(lat_lo, lat_hi));
        red_glitch = 1'($urandom_range(0, 1));
        check_eq("mod_X", mod_X, {{(BITS+1){1'b0}}, cur_n});
      end
      if (red_k >= red_lat) begin
        mod_done = 1'b1;
        mod_R    = (mod_X == '0) ? '0 : BITS'(mod_Y % mod_X);
      end else if (red_glitch && red_k <= 2) begin
        mod_done = 1'b1;
        mod_R    = rand_wide();
      end else begin
        mod_done = 1'b0;
      end
    end

    if (mod_go) begin
      go_seen = 1'b1;
      if (!prev_go) begin
        go_rises++;
        if (had_fall) check_eq("mod_gap", 1'(low_cnt >= int'(MOD_GAP)), 1);
      end
    end else begin
      if (prev_go) begin
        had_fall = 1'b1;
        low_cnt  = 0;
      end
      low_cnt++;
    end
    prev_go = mod_go;
  end

  task automatic do_op(input logic [BITS-1:0] m, input logic [BITS-1:0] e, input logic [BITS-1:0] n,
                       input logic [BITS-1:0] exp_c, input logic exp_err, input int poke,
                       input string tag);
    int cyc;
    @(negedge clk);
    M = m; E = e; N = n; start = 1'b1;
    cur_n   = n;
    go_seen = 1'b0;
    @(negedge clk);
    start = 1'b0;
    M = rand_wide(); E = rand_wide(); N = rand_wide();
    check_eq({tag, ":busy"}, busy, 1);
    cyc = 1;
    while (!done && cyc < TIMEOUT) begin
      start = (cyc == poke);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      check_eq({tag, ":timeout"}, 0, 1);
    end else begin
      check_eq({tag, ":C"}, C, exp_c);
      check_eq({tag, ":err"}, err, exp_err);
      if (exp_err) begin
        check_eq({tag, ":err_latency"}, 1'(cyc <= 3), 1);
        check_eq({tag, ":no_mod_go"}, go_seen, 0);
      end
      @(negedge clk);
      check_eq({tag, ":done_pulse"}, done, 0);
      check_eq({tag, ":idle"}, busy, 0);
      check_eq({tag, ":C_held"}, C, exp_c);
    end
  endtask

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

  initial begin
    logic [BITS-1:0] m, e, n;
    int cyc, rises0, w;
    reset = 1'b1; start = 1'b0; M = '0; E = '0; N = '0; cur_n = '0;
    repeat (3) @(negedge clk);
    check_eq("rst:busy", busy, 0);
    check_eq("rst:done", done, 0);
    check_eq("rst:err", err, 0);
    check_eq("rst:C", C, 0);
    check_eq("rst:mod_go", mod_go, 0);
    reset = 1'b0;

    do_op(5, 3, 13, 8, 1'b0, -1, "m5e3n13");
    do_op(7, 0, 11, 1, 1'b0, -1, "e0n11");
    do_op(rand_wide(), rand_wide(), 1, 0, 1'b0, -1, "n1");
    do_op(7, 0, 1, 0, 1'b0, -1, "e0n1");
    do_op(BITS'(32'h1234), 5, 0, 0, 1'b1, -1, "n0");
    do_op(2, 10, 1000, 24, 1'b0, 20, "busy_start");

    // Reset while in the first squaring reduction (third mod_go request)
    @(negedge clk);
    M = 5; E = 3; N = 13; cur_n = 13; start = 1'b1;
    rises0 = go_rises;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (go_rises < rises0 + 3 && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rstmid:in_red_b", mod_go, 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rstmid:mod_go", mod_go, 0);
    check_eq("rstmid:busy", busy, 0);
    check_eq("rstmid:C", C, 0);
    reset = 1'b0;
    do_op(5, 3, 13, 8, 1'b0, -1, "after_rst");

    // Full-width exponent, exercising all BITS exponent bits
    m = rand_wide(); n = rand_wide() | BITS'(1);
    e = '1;
    do_op(m, e, n, golden(m, e, n), 1'b0, -1, "full_e");

    // Random operands, mostly short exponents, occasional long reductions
    long_pct = 5;
    for (int i = 0; i < 50; i++) begin
      w = int'($urandom_range(1, 16));
      m = rand_wide();
      n = rand_wide() >> $urandom_range(0, 120);
      e = rand_wide() >> (int'(BITS) - w);
      do_op(m, e, n, golden(m, e, n), 1'(n == '0), -1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
